// File: rtl/half_adder.sv
// Lane-parallel registered half adder: sum = a ^ b and carry = a & b per lane, with carry_any = |carry.
// Latency is PIPE_STAGES edges, counting the sampling edge. Accepts one result per cycle with no backpressure.
module half_adder #(
    parameter int WIDTH       = 1,
    parameter int PIPE_STAGES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_carry,
    output logic             o_carry_any
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic             w_carry_any;

    assign w_sum       = i_a ^ i_b;
    assign w_carry     = i_a & i_b;
    assign w_carry_any = |w_carry;

    logic             r_vld  [PIPE_STAGES];
    logic [WIDTH-1:0] r_sum  [PIPE_STAGES];
    logic [WIDTH-1:0] r_carry[PIPE_STAGES];
    logic             r_cany [PIPE_STAGES];

    // Data registers load only behind a valid bit, so idle X inputs never enter the pipe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_vld[s]   <= 1'b0;
                r_sum[s]   <= '0;
                r_carry[s] <= '0;
                r_cany[s]  <= 1'b0;
            end
        end else begin
            r_vld[0] <= i_in_valid;
            if (i_in_valid) begin
                r_sum[0]   <= w_sum;
                r_carry[0] <= w_carry;
                r_cany[0]  <= w_carry_any;
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_sum[s]   <= r_sum[s-1];
                    r_carry[s] <= r_carry[s-1];
                    r_cany[s]  <= r_cany[s-1];
                end
            end
        end
    end

    assign o_out_valid = r_vld[PIPE_STAGES-1];
    assign o_sum       = r_sum[PIPE_STAGES-1];
    assign o_carry     = r_carry[PIPE_STAGES-1];
    assign o_carry_any = r_cany[PIPE_STAGES-1];

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder across four width/pipe configurations.
module tb_half_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // W1P1
    logic v1 = 0, a1 = 0, b1 = 0, ov1, s1, c1, ca1;
    // W1P3
    logic v13 = 0, a13 = 0, b13 = 0, ov13, s13, c13, ca13;
    // W8P3
    logic v83 = 0, ov83, ca83;
    logic [7:0] a83 = 0, b83 = 0, s83, c83;
    // W8P2
    logic v82 = 0, ov82, ca82;
    logic [7:0] a82 = 0, b82 = 0, s82, c82;

    half_adder #(.WIDTH(1), .PIPE_STAGES(1)) u_w1p1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v1), .i_a(a1), .i_b(b1),
        .o_out_valid(ov1), .o_sum(s1), .o_carry(c1), .o_carry_any(ca1));
    half_adder #(.WIDTH(1), .PIPE_STAGES(3)) u_w1p3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v13), .i_a(a13), .i_b(b13),
        .o_out_valid(ov13), .o_sum(s13), .o_carry(c13), .o_carry_any(ca13));
    half_adder #(.WIDTH(8), .PIPE_STAGES(3)) u_w8p3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v83), .i_a(a83), .i_b(b83),
        .o_out_valid(ov83), .o_sum(s83), .o_carry(c83), .o_carry_any(ca83));
    half_adder #(.WIDTH(8), .PIPE_STAGES(2)) u_w8p2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v82), .i_a(a82), .i_b(b82),
        .o_out_valid(ov82), .o_sum(s82), .o_carry(c82), .o_carry_any(ca82));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each lane adds two 1-bit numbers; low bit is sum, high bit is carry.
    function automatic void ref_add(input logic [7:0] a, input logic [7:0] b, input int w,
                                    output logic [7:0] s, output logic [7:0] c);
        s = '0;
        c = '0;
        for (int i = 0; i < w; i++) begin
            int t;
            t = int'(a[i]) + int'(b[i]);
            s[i] = (t % 2) != 0;
            c[i] = (t / 2) != 0;
        end
    endfunction

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } vec1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] c;
        logic       ca;
    } vec8_t;

    localparam int NRAND = 1000;
    logic       rv[NRAND];
    logic [7:0] ra[NRAND];
    logic [7:0] rb[NRAND];

    task automatic do_reset();
        rst_n = 1'b0;
        v1 = 0; v13 = 0; v83 = 0; v82 = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vec1_t t1[4];
        vec8_t t2[3];
        logic [7:0] es, ec, l1s, l1c, l3s, l3c, l8s, l8c;
        logic e1v, e3v, e8v;

        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
        t1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        t1[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        t2[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        t2[1] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1};
        t2[2] = '{8'h0F, 8'hF0, 8'hFF, 8'h00, 1'b0};

        // Reset state
        do_reset();
        chk("rst_w1p1_vld", 64'(ov1), 0);
        chk("rst_w1p1_dat", 64'({s1, c1, ca1}), 0);
        chk("rst_w8p3_vld", 64'(ov83), 0);
        chk("rst_w8p3_dat", 64'({s83, c83, ca83}), 0);
        chk("rst_w8p2_dat", 64'({ov82, s82, c82, ca82}), 0);
        chk("rst_w1p3_dat", 64'({ov13, s13, c13, ca13}), 0);

        // W1P1 truth table, each row held 10 cycles
        foreach (t1[k]) begin
            v1 = 1'b1; a1 = t1[k].a; b1 = t1[k].b;
            for (int n = 0; n < 10; n++) begin
                tick();
                chk("tt_vld", 64'(ov1), 1);
                chk("tt_sum", 64'(s1), 64'(t1[k].s));
                chk("tt_carry", 64'(c1), 64'(t1[k].c));
                chk("tt_cany", 64'(ca1), 64'(t1[k].c));
            end
        end
        v1 = 1'b0;

        // W8P3 single pulse: result visible after the third edge, for one cycle
        v83 = 1'b1; a83 = 8'hF0; b83 = 8'hAA;
        tick();
        v83 = 1'b0; a83 = 8'($urandom); b83 = 8'($urandom);
        chk("p3_vld_e1", 64'(ov83), 0);
        tick();
        chk("p3_vld_e2", 64'(ov83), 0);
        tick();
        chk("p3_vld_e3", 64'(ov83), 1);
        chk("p3_sum", 64'(s83), 64'h5A);
        chk("p3_carry", 64'(c83), 64'hA0);
        chk("p3_cany", 64'(ca83), 1);
        tick();
        chk("p3_vld_e4", 64'(ov83), 0);
        chk("p3_hold_sum", 64'(s83), 64'h5A);

        // W8P2 back-to-back
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                v82 = 1'b1; a82 = t2[k].a; b82 = t2[k].b;
            end else begin
                v82 = 1'b0;
            end
            tick();
            if (k > 0) begin
                chk("b2b_vld", 64'(ov82), 1);
                chk("b2b_sum", 64'(s82), 64'(t2[k-1].s));
                chk("b2b_carry", 64'(c82), 64'(t2[k-1].c));
                chk("b2b_cany", 64'(ca82), 64'(t2[k-1].ca));
            end
        end
        // Idle gap with random operands: outputs hold the last result
        for (int k = 0; k < 3; k++) begin
            v82 = 1'b0; a82 = 8'($urandom); b82 = 8'($urandom);
            tick();
            chk("gap_vld", 64'(ov82), 0);
            chk("gap_sum", 64'(s82), 64'hFF);
            chk("gap_carry", 64'(c82), 64'h00);
        end

        // Reset one cycle after in_valid drops the in-flight result
        v83 = 1'b1; a83 = 8'hFF; b83 = 8'hFF;
        tick();
        v83 = 1'b0; rst_n = 1'b0;
        tick();
        chk("mid_rst_dat", 64'({ov83, s83, c83, ca83}), 0);
        chk("mid_rst_p2", 64'({ov82, s82, c82, ca82}), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_rst_vld", 64'(ov83), 0);
        end

        // Random phase against the arithmetic reference
        do_reset();
        l1s = 0; l1c = 0; l3s = 0; l3c = 0; l8s = 0; l8c = 0;
        for (int t = 0; t < NRAND; t++) begin
            rv[t] = ($urandom_range(0, 3) != 0);
            ra[t] = 8'($urandom);
            rb[t] = 8'($urandom);
            v1 = rv[t];  a1 = ra[t][0];  b1 = rb[t][0];
            v13 = rv[t]; a13 = ra[t][1]; b13 = rb[t][1];
            v83 = rv[t]; a83 = ra[t];    b83 = rb[t];
            tick();
            e1v = rv[t];
            if (e1v) ref_add(ra[t], rb[t], 1, l1s, l1c);
            e3v = (t >= 2) ? rv[t-2] : 1'b0;
            if (e3v) begin
                ref_add(ra[t-2] >> 1, rb[t-2] >> 1, 1, l3s, l3c);
                ref_add(ra[t-2], rb[t-2], 8, l8s, l8c);
            end
            e8v = e3v;
            chk("rnd_w1p1_vld", 64'(ov1), 64'(e1v));
            chk("rnd_w1p1_sc", 64'({s1, c1, ca1}), 64'({l1s[0], l1c[0], l1c[0]}));
            chk("rnd_w1p3_vld", 64'(ov13), 64'(e3v));
            chk("rnd_w1p3_sc", 64'({s13, c13, ca13}), 64'({l3s[0], l3c[0], l3c[0]}));
            chk("rnd_w8p3_vld", 64'(ov83), 64'(e8v));
            chk("rnd_w8p3_sum", 64'(s83), 64'(l8s));
            chk("rnd_w8p3_carry", 64'(c83), 64'(l8c));
            chk("rnd_w8p3_cany", 64'(ca83), 64'(l8c != 0));
        end
        es = 0; ec = 0;
        ref_add(8'h3C, 8'h0F, 8, es, ec);
        v1 = 0; v13 = 0; v83 = 1'b1; a83 = 8'h3C; b83 = 8'h0F;
        tick();
        v83 = 1'b0;
        tick();
        tick();
        chk("final_sum", 64'(s83), 64'(es));
        chk("final_carry", 64'(c83), 64'(ec));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
